spi_master_write: RTL and testbench

SPI_MASTER_WRITE -- requirements
Module: spi_master_write

---
 rtl/spi_master_write_if.sv | 13 +
 rtl/spi_master_write.sv | 76 +++++++
 tb/tb_spi_master_write.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_write_if.sv
// spi_master_write_if: request and serial-bus signals of the SPI register-write master.
interface spi_master_write_if;
  logic       req;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic       cs;
  logic       sclk;
  logic       sdata;
  modport master (input req, addr, wdata, output ready, done, cs, sclk, sdata);
  modport slave  (output req, addr, wdata, input ready, done, cs, sclk, sdata);
endinterface

// File: rtl/spi_master_write.sv
// spi_master_write: serializes one {addr,wdata} word per request as an SPI write frame.
module spi_master_write #(
  parameter int HALF = 4
) (
  input logic clk,
  input logic rst,
  spi_master_write_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;
  localparam logic [7:0] LAST  = 8'(HALF - 1);
  logic [1:0]  state;
  logic [7:0]  phase;
  logic [3:0]  bit_cnt;
  logic [15:0] sr;
  logic        ready, done, cs, sclk;
  logic        phase_end;
  assign phase_end = phase == LAST;
  // sdata comes straight from the shift register's MSB flop, which is cleared outside a frame
  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.cs    = cs;
  assign bus.sclk  = sclk;
  assign bus.sdata = sr[15];
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          state   <= SHIFT;
          sr      <= {bus.addr, bus.wdata};
          bit_cnt <= 4'd15;
          phase   <= '0;
          cs      <= 1'b0;
          ready   <= 1'b0;
        end
        SHIFT: if (!phase_end) phase <= phase + 8'd1;
        else begin
          phase <= '0;
          sclk  <= ~sclk;
          // end of a high phase: either advance to the next bit or finish with bit 0 held
          if (sclk && bit_cnt == 4'd0) state <= HOLD;
          else if (sclk) begin
            bit_cnt <= bit_cnt - 4'd1;
            sr      <= {sr[14:0], 1'b0};
          end
        end
        HOLD: if (!phase_end) phase <= phase + 8'd1;
        else begin
          phase <= '0;
          state <= GAP;
          cs    <= 1'b1;
          sr    <= '0;
        end
        GAP: if (!phase_end) phase <= phase + 8'd1;
        else begin
          phase <= '0;
          state <= IDLE;
          done  <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_write.sv
// tb_spi_master_write: directed vectors against HALF=4 and HALF=1 instances with a slave model.
module tb_spi_master_write;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_master_write_if b4 ();
  spi_master_write_if b1 ();
  spi_master_write #(.HALF(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  spi_master_write #(.HALF(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  logic       req = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  assign b4.req = req & ~sel;
  assign b1.req = req & sel;
  assign b4.addr = addr;
  assign b1.addr = addr;
  assign b4.wdata = wdata;
  assign b1.wdata = wdata;
  logic o_ready, o_done, o_cs, o_sclk, o_sdata;
  int half;
  assign o_ready = sel ? b1.ready : b4.ready;
  assign o_done  = sel ? b1.done  : b4.done;
  assign o_cs    = sel ? b1.cs    : b4.cs;
  assign o_sclk  = sel ? b1.sclk  : b4.sclk;
  assign o_sdata = sel ? b1.sdata : b4.sdata;
  assign half    = sel ? 1 : 4;
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // slave model and timing monitor, sampled on the falling edge
  int cyc = 0, rises = 0, dones = 0, commits = 0, viol = 0, sp_err = 0;
  int fall_cyc = 0, rise_cyc = 0, done_cyc = 0, last_rise = 0, bits = 0;
  logic [15:0] sh = '0;
  logic [7:0]  regs [256];
  logic first = 1'b0, p_cs = 1'b1, p_sclk = 1'b0, p_sdata = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (p_cs && !o_cs) begin
      fall_cyc = cyc;
      bits = 0;
      first = 1'b1;
    end
    if (!p_cs && o_cs) begin
      rise_cyc = cyc;
      if (bits == 16) begin
        regs[sh[15:8]] = sh[7:0];
        commits++;
      end
    end
    if (!p_sclk && o_sclk) begin
      rises++;
      bits++;
      sh = {sh[14:0], o_sdata};
      if (o_cs) viol++;
      if (first ? (cyc - fall_cyc != half) : (cyc - last_rise != 2 * half)) sp_err++;
      first = 1'b0;
      last_rise = cyc;
    end
    if (!p_cs && !o_cs && o_sdata !== p_sdata && !(p_sclk && !o_sclk)) viol++;
    if (o_done) begin
      dones++;
      done_cyc = cyc;
    end
    p_cs = o_cs;
    p_sclk = o_sclk;
    p_sdata = o_sdata;
  end
  // waits for DONE; optionally scrambles inputs and fires an illegal mid-frame request
  task automatic wait_done(input int lim, input bit scr, output bit seen, output int rbad);
    seen = 1'b0;
    rbad = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_ready) rbad++;
      if (scr) begin
        addr = 8'($urandom);
        wdata = 8'($urandom);
        req = (i >= 3 && i <= 6);
      end
    end
    if (!seen) $display("FAIL done_timeout: got no DONE within %0d cycles", lim);
  endtask
  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] w;
    int         cs_low;
    int         done_dly;
  } vec_t;
  task automatic run_vec(input vec_t v);
    int r0, d0, v0, e0, rbad;
    bit seen;
    sel = v.s;
    @(negedge clk);
    #1;
    r0 = rises; d0 = dones; v0 = viol; e0 = sp_err;
    chk("ready_idle", 32'(o_ready), 32'd1);
    addr = v.a; wdata = v.w; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("cs_after_accept", 32'(o_cs), 32'd0);
    chk("sdata_bit15", 32'(o_sdata), 32'(v.a[7]));
    wait_done(200, 1'b1, seen, rbad);
    req = 1'b0;
    #1;
    chk("done_seen", 32'(seen), 32'd1);
    chk("ready_low_in_frame", 32'(rbad), 32'd0);
    chk("ready_at_done", 32'(o_ready), 32'd1);
    chk("word", 32'(sh), 32'({v.a, v.w}));
    chk("rise_count", 32'(rises - r0), 32'd16);
    chk("done_count", 32'(dones - d0), 32'd1);
    chk("cs_low_len", 32'(rise_cyc - fall_cyc), 32'(v.cs_low));
    chk("done_delay", 32'(done_cyc - fall_cyc), 32'(v.done_dly));
    chk("sdata_stable", 32'(viol - v0), 32'd0);
    chk("sclk_spacing", 32'(sp_err - e0), 32'd0);
    chk("slave_reg", 32'(regs[v.a]), 32'(v.w));
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 32'd0);
  endtask
  vec_t vecs [5];
  initial begin
    int rbad, r0, d0, c0, dc1, rc1;
    bit seen;
    vecs[0] = '{1'b0, 8'h00, 8'hA5, 132, 136};
    vecs[1] = '{1'b1, 8'hFF, 8'h01, 33, 34};
    vecs[2] = '{1'b0, 8'h5A, 8'h3C, 132, 136};
    vecs[3] = '{1'b1, 8'h80, 8'hFE, 33, 34};
    vecs[4] = '{1'b1, 8'h00, 8'h00, 33, 34};
    repeat (3) @(negedge clk);
    chk("rst_ready4", 32'(b4.ready), 32'd1);
    chk("rst_cs4", 32'(b4.cs), 32'd1);
    chk("rst_sclk4", 32'(b4.sclk), 32'd0);
    chk("rst_sdata4", 32'(b4.sdata), 32'd0);
    chk("rst_done4", 32'(b4.done), 32'd0);
    chk("rst_ready1", 32'(b1.ready), 32'd1);
    chk("rst_cs1", 32'(b1.cs), 32'd1);
    chk("rst_done1", 32'(b1.done), 32'd0);
    sel = 1'b1; addr = 8'h42; wdata = 8'h99; req = 1'b1; rst = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("first_edge_accept", 32'(o_cs), 32'd0);
    wait_done(100, 1'b0, seen, rbad);
    #1;
    chk("first_frame_reg", 32'(regs[8'h42]), 32'h99);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    // back-to-back frames with REQ held through DONE
    sel = 1'b0;
    @(negedge clk);
    addr = 8'h01; wdata = 8'h3C; req = 1'b1;
    @(negedge clk);
    wdata = 8'hC3;
    wait_done(200, 1'b0, seen, rbad);
    #1;
    dc1 = done_cyc; rc1 = rise_cyc;
    chk("b2b_first_reg", 32'(regs[8'h01]), 32'h3C);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("b2b_fall_after_done", 32'(fall_cyc - dc1), 32'd1);
    chk("b2b_cs_high", 32'(fall_cyc - rc1), 32'd5);
    wait_done(200, 1'b0, seen, rbad);
    #1;
    chk("b2b_second_reg", 32'(regs[8'h01]), 32'hC3);
    chk("b2b_word", 32'(sh), 32'h01C3);
    // reset at the 5th SCLK rise
    @(negedge clk);
    addr = 8'h77; wdata = 8'h11; req = 1'b1;
    #1;
    r0 = rises;
    @(negedge clk);
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rises - r0 >= 5) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fifth_rise_seen", 32'(seen), 32'd1);
    chk("sclk_high_at_5th", 32'(o_sclk), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cs", 32'(o_cs), 32'd1);
    chk("mid_rst_sclk", 32'(o_sclk), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_sdata", 32'(o_sdata), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    #1;
    r0 = rises; d0 = dones; c0 = commits;
    repeat (40) @(negedge clk);
    #1;
    chk("no_rise_after_rst", 32'(rises - r0), 32'd0);
    chk("no_done_after_rst", 32'(dones - d0), 32'd0);
    chk("no_commit_after_rst", 32'(commits - c0), 32'd0);
    run_vec('{1'b0, 8'hC7, 8'h5E, 132, 136});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
